// File: rtl/walksat_flip_engine.sv
// WalkSAT flip selector: issues one break lookup per literal of a clause, then picks the variable to flip.
// Optional statistics counters are enabled with `define SAT_FLIP_STATS_EN.
module walksat_flip_engine #(
    parameter int          NSAT          = 3,
    parameter int          NUM_VARIABLES = 2048,
    parameter int          MC            = 20,
    parameter logic [31:0] P_THRESH      = 32'h6E147AE0,
    localparam int         VAW           = $clog2(NUM_VARIABLES),
    localparam int         LAW           = VAW + 1,
    localparam int         BW            = $clog2(MC + 1),
    localparam int         IDXW          = (NSAT > 1) ? $clog2(NSAT) : 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clause_valid_i,
    output logic                  clause_ready_o,
    input  logic [NSAT*LAW-1:0]   clause_i,
    input  logic [31:0]           random_i,
    output logic                  lk_valid_o,
    output logic [LAW-1:0]        lk_literal_o,
    output logic [IDXW-1:0]       lk_index_o,
    input  logic                  rsp_valid_i,
    input  logic [MC-1:0]         rsp_break_i,
    input  logic [MC-1:0]         rsp_mask_i,
    output logic                  flip_valid_o,
    input  logic                  flip_ready_i,
    output logic [LAW-1:0]        flip_literal_o,
    output logic [IDXW-1:0]       flip_index_o,
    output logic [BW-1:0]         flip_break_o,
    output logic [1:0]            flip_mode_o,
    output logic                  busy_o,
`ifdef SAT_FLIP_STATS_EN
    output logic                  err_o,
    output logic [31:0]           stat_flips_o,
    output logic [31:0]           stat_freebies_o
`else
    output logic                  err_o
`endif
);

    localparam int CW = $clog2(NSAT + 1);
    localparam int PW = 16 + CW;

    // IDLE | await clause; ISSUE | one lookup per cycle; WAIT | drain responses; DECIDE | select; OUTPUT | hold flip
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DECIDE,
        S_OUTPUT
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [LAW-1:0]  r_lit [NSAT];
    logic [BW-1:0]   r_brk [NSAT];
    logic [CW-1:0]   r_k;
    logic [CW-1:0]   r_r;
    logic [BW-1:0]   r_min_brk;
    logic [IDXW-1:0] r_min_idx;
    logic            r_err;

    logic [LAW-1:0]  r_flip_literal;
    logic [IDXW-1:0] r_flip_index;
    logic [BW-1:0]   r_flip_break;
    logic [1:0]      r_flip_mode;

    logic            w_accept_clause;
    logic            w_outstanding;
    logic            w_rsp_take;
    logic            w_rsp_stray;
    logic            w_last_rsp;
    logic            w_flip_hs;
    logic [BW-1:0]   w_rsp_brk;
    logic [IDXW-1:0] w_k_idx;
    logic [IDXW-1:0] w_r_idx;
    logic [IDXW-1:0] w_rand_idx;
    logic [IDXW-1:0] w_sel_idx;
    logic [1:0]      w_sel_mode;

    function automatic logic [BW-1:0] popcount(input logic [MC-1:0] v);
        logic [BW-1:0] c;
        c = '0;
        for (int i = 0; i < MC; i++) begin
            c = c + BW'(v[i]);
        end
        return c;
    endfunction

    assign w_accept_clause = clause_valid_i & clause_ready_o;
    assign w_outstanding   = (r_k != r_r);
    assign w_rsp_take      = rsp_valid_i & w_outstanding;
    assign w_rsp_stray     = rsp_valid_i & ~w_outstanding;
    assign w_last_rsp      = w_rsp_take && (r_r == CW'(NSAT - 1));
    assign w_flip_hs       = (r_state == S_OUTPUT) & flip_ready_i;
    assign w_rsp_brk       = popcount(rsp_break_i & rsp_mask_i);
    assign w_k_idx         = r_k[IDXW-1:0];
    assign w_r_idx         = r_r[IDXW-1:0];

    // Scales the low 16 random bits into 0..NSAT-1 without a divider.
    assign w_rand_idx = IDXW'((PW'(random_i[15:0]) * PW'(NSAT)) >> 16);

    always_comb begin
        w_sel_mode = 2'd2;
        w_sel_idx  = r_min_idx;
        if (r_min_brk == '0) begin
            w_sel_mode = 2'd0;
        end else if (random_i < P_THRESH) begin
            w_sel_mode = 2'd1;
            w_sel_idx  = w_rand_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept_clause) w_next_state = S_ISSUE;
            S_ISSUE:  if (r_k == CW'(NSAT - 1)) w_next_state = S_WAIT;
            S_WAIT:   if ((r_r == CW'(NSAT)) || w_last_rsp) w_next_state = S_DECIDE;
            S_DECIDE: w_next_state = S_OUTPUT;
            S_OUTPUT: if (w_flip_hs) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSAT; i++) begin
                r_lit[i] <= '0;
                r_brk[i] <= '0;
            end
            r_k       <= '0;
            r_r       <= '0;
            r_min_brk <= '0;
            r_min_idx <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept_clause) begin
                for (int i = 0; i < NSAT; i++) begin
                    r_lit[i] <= clause_i[i*LAW +: LAW];
                end
                r_k <= '0;
                r_r <= '0;
            end else begin
                if (r_state == S_ISSUE) begin
                    r_k <= r_k + CW'(1);
                end
                // Strict less-than keeps the earliest index on ties.
                if (w_rsp_take) begin
                    r_brk[w_r_idx] <= w_rsp_brk;
                    r_r            <= r_r + CW'(1);
                    if ((r_r == '0) || (w_rsp_brk < r_min_brk)) begin
                        r_min_brk <= w_rsp_brk;
                        r_min_idx <= w_r_idx;
                    end
                end
            end
            if (w_rsp_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flip_literal <= '0;
            r_flip_index   <= '0;
            r_flip_break   <= '0;
            r_flip_mode    <= '0;
        end else if (r_state == S_DECIDE) begin
            r_flip_literal <= r_lit[w_sel_idx];
            r_flip_index   <= w_sel_idx;
            r_flip_break   <= r_brk[w_sel_idx];
            r_flip_mode    <= w_sel_mode;
        end
    end

    assign clause_ready_o = (r_state == S_IDLE) && !reset;
    assign lk_valid_o     = (r_state == S_ISSUE);
    assign lk_index_o     = lk_valid_o ? w_k_idx : '0;
    assign lk_literal_o   = lk_valid_o ? (r_lit[w_k_idx] ^ {1'b1, {(LAW-1){1'b0}}}) : '0;
    assign flip_valid_o   = (r_state == S_OUTPUT);
    assign flip_literal_o = r_flip_literal;
    assign flip_index_o   = r_flip_index;
    assign flip_break_o   = r_flip_break;
    assign flip_mode_o    = r_flip_mode;
    assign busy_o         = (r_state != S_IDLE);
    assign err_o          = r_err;

`ifdef SAT_FLIP_STATS_EN
    logic [31:0] r_stat_flips;
    logic [31:0] r_stat_freebies;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_flips    <= '0;
            r_stat_freebies <= '0;
        end else if (w_flip_hs) begin
            r_stat_flips <= r_stat_flips + 32'd1;
            if (r_flip_mode == 2'd0) begin
                r_stat_freebies <= r_stat_freebies + 32'd1;
            end
        end
    end

    assign stat_flips_o    = r_stat_flips;
    assign stat_freebies_o = r_stat_freebies;
`endif

endmodule

// File: tb/tb_walksat_flip_engine.sv
// Directed bench for walksat_flip_engine with a fixed three-cycle lookup responder.
module tb_walksat_flip_engine;

    localparam int NSAT = 3;
    localparam int LAW  = 12;
    localparam int MC   = 20;
    localparam int BW   = 5;
    localparam int IDXW = 2;
    localparam int CLW  = NSAT * LAW;

    localparam logic [CLW-1:0] CL_A = {12'h123, 12'h80A, 12'h005};
    localparam logic [CLW-1:0] CL_B = {12'h7FF, 12'h444, 12'h9C3};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            clause_valid_i = 1'b0;
    logic            clause_ready_o;
    logic [CLW-1:0]  clause_i = '0;
    logic [31:0]     random_i = '0;
    logic            lk_valid_o;
    logic [LAW-1:0]  lk_literal_o;
    logic [IDXW-1:0] lk_index_o;
    logic            rsp_valid_i = 1'b0;
    logic [MC-1:0]   rsp_break_i = '0;
    logic [MC-1:0]   rsp_mask_i = '0;
    logic            flip_valid_o;
    logic            flip_ready_i = 1'b0;
    logic [LAW-1:0]  flip_literal_o;
    logic [IDXW-1:0] flip_index_o;
    logic [BW-1:0]   flip_break_o;
    logic [1:0]      flip_mode_o;
    logic            busy_o;
    logic            err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [MC-1:0]   tb_brk [NSAT];
    logic [MC-1:0]   tb_msk [NSAT];
    logic            pipe_v [3];
    logic [IDXW-1:0] pipe_idx [3];
    int              stray_req = 0;
    int              stray_done = 0;

    walksat_flip_engine dut (
        .clk            (clk),
        .reset          (reset),
        .clause_valid_i (clause_valid_i),
        .clause_ready_o (clause_ready_o),
        .clause_i       (clause_i),
        .random_i       (random_i),
        .lk_valid_o     (lk_valid_o),
        .lk_literal_o   (lk_literal_o),
        .lk_index_o     (lk_index_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_break_i    (rsp_break_i),
        .rsp_mask_i     (rsp_mask_i),
        .flip_valid_o   (flip_valid_o),
        .flip_ready_i   (flip_ready_i),
        .flip_literal_o (flip_literal_o),
        .flip_index_o   (flip_index_o),
        .flip_break_o   (flip_break_o),
        .flip_mode_o    (flip_mode_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    // Lookup stack model: answers each request exactly three cycles later; flushed by reset.
    task automatic responder();
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < 3; i++) pipe_v[i] = 1'b0;
                rsp_valid_i = 1'b0;
                rsp_break_i = '0;
                rsp_mask_i  = '0;
            end else begin
                rsp_valid_i = pipe_v[2];
                rsp_break_i = pipe_v[2] ? tb_brk[pipe_idx[2]] : '0;
                rsp_mask_i  = pipe_v[2] ? tb_msk[pipe_idx[2]] : '0;
                if (!pipe_v[2] && (stray_req != stray_done)) begin
                    rsp_valid_i = 1'b1;
                    rsp_break_i = 20'h00001;
                    rsp_mask_i  = 20'h00001;
                    stray_done++;
                end
                pipe_v[2]   = pipe_v[1];
                pipe_idx[2] = pipe_idx[1];
                pipe_v[1]   = pipe_v[0];
                pipe_idx[1] = pipe_idx[0];
                pipe_v[0]   = lk_valid_o;
                pipe_idx[0] = lk_index_o;
            end
        end
    endtask

    task automatic set_breaks(input logic [MC-1:0] b0, input logic [MC-1:0] m0,
                              input logic [MC-1:0] b1, input logic [MC-1:0] m1,
                              input logic [MC-1:0] b2, input logic [MC-1:0] m2);
        tb_brk[0] = b0; tb_msk[0] = m0;
        tb_brk[1] = b1; tb_msk[1] = m1;
        tb_brk[2] = b2; tb_msk[2] = m2;
    endtask

    // Offers a clause and returns at the negedge of the first cycle after acceptance.
    task automatic start_clause(input logic [CLW-1:0] cl, input bit keep);
        int t;
        t = 0;
        while (!clause_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!clause_ready_o) begin
            n_cmp++; n_bad++;
            $display("FAIL start_timeout clause_ready_o got %0b want 1", clause_ready_o);
        end
        clause_i = cl;
        clause_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) clause_valid_i = 1'b0;
    endtask

    task automatic wait_flip(input int start_n, output int n);
        n = start_n;
        while (!flip_valid_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!flip_valid_o) begin
            n_cmp++; n_bad++;
            $display("FAIL flip_timeout flip_valid_o got 0 want 1 after %0d cycles", n);
        end
    endtask

    task automatic finish_flip();
        flip_ready_i = 1'b1;
        @(negedge clk);
        flip_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (clause_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_clause_ready got %0b want 1", clause_ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0b want 0", busy_o); end
        n_cmp++; if (lk_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_lk_valid got %0b want 0", lk_valid_o); end
        n_cmp++; if (lk_literal_o !== '0) begin n_bad++; $display("FAIL rst_lk_literal got %0h want 0", lk_literal_o); end
        n_cmp++; if (flip_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_flip_valid got %0b want 0", flip_valid_o); end
        n_cmp++; if (flip_literal_o !== '0) begin n_bad++; $display("FAIL rst_flip_literal got %0h want 0", flip_literal_o); end
        n_cmp++; if (flip_mode_o !== 2'd0) begin n_bad++; $display("FAIL rst_flip_mode got %0d want 0", flip_mode_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0b want 0", err_o); end
    endtask

    task automatic test_freebie();
        logic [LAW-1:0] lk_exp [NSAT];
        int n;
        lk_exp[0] = 12'h805; lk_exp[1] = 12'h00A; lk_exp[2] = 12'h923;
        set_breaks(20'h00007, 20'hFFFFF, 20'hFFFFF, 20'h00000, 20'hF0003, 20'h0FFFF);
        random_i = 32'h0;
        start_clause(CL_A, 1'b0);
        for (int c = 0; c < NSAT; c++) begin
            n_cmp++; if (lk_valid_o !== 1'b1) begin n_bad++; $display("FAIL issue_valid k=%0d got %0b want 1", c, lk_valid_o); end
            n_cmp++; if (lk_index_o !== IDXW'(c)) begin n_bad++; $display("FAIL issue_index got %0d want %0d", lk_index_o, c); end
            n_cmp++; if (lk_literal_o !== lk_exp[c]) begin n_bad++; $display("FAIL issue_literal k=%0d got %0h want %0h", c, lk_literal_o, lk_exp[c]); end
            @(negedge clk);
        end
        n_cmp++; if (lk_valid_o !== 1'b0) begin n_bad++; $display("FAIL issue_stop got %0b want 0", lk_valid_o); end
        wait_flip(NSAT + 1, n);
        n_cmp++; if (flip_mode_o !== 2'd0) begin n_bad++; $display("FAIL freebie_mode got %0d want 0", flip_mode_o); end
        n_cmp++; if (flip_index_o !== 2'd1) begin n_bad++; $display("FAIL freebie_index got %0d want 1", flip_index_o); end
        n_cmp++; if (flip_break_o !== 5'd0) begin n_bad++; $display("FAIL freebie_break got %0d want 0", flip_break_o); end
        n_cmp++; if (flip_literal_o !== 12'h80A) begin n_bad++; $display("FAIL freebie_literal got %0h want 80a", flip_literal_o); end
        finish_flip();
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL freebie_err got %0b want 0", err_o); end
    endtask

    task automatic test_greedy();
        int n;
        set_breaks(20'h00101, 20'hFFFFF, 20'h80000, 20'hFFFFF, 20'h00040, 20'hFFFFF);
        random_i = 32'hFFFFFFFF;
        start_clause(CL_A, 1'b0);
        wait_flip(1, n);
        n_cmp++; if (flip_mode_o !== 2'd2) begin n_bad++; $display("FAIL greedy_mode got %0d want 2", flip_mode_o); end
        n_cmp++; if (flip_index_o !== 2'd1) begin n_bad++; $display("FAIL greedy_index got %0d want 1", flip_index_o); end
        n_cmp++; if (flip_break_o !== 5'd1) begin n_bad++; $display("FAIL greedy_break got %0d want 1", flip_break_o); end
        n_cmp++; if (flip_literal_o !== 12'h80A) begin n_bad++; $display("FAIL greedy_literal got %0h want 80a", flip_literal_o); end
        finish_flip();
    endtask

    task automatic test_random();
        int n;
        set_breaks(20'h00101, 20'hFFFFF, 20'h80000, 20'hFFFFF, 20'h00040, 20'hFFFFF);
        random_i = 32'h0000FFFF;
        start_clause(CL_A, 1'b0);
        wait_flip(1, n);
        n_cmp++; if (flip_mode_o !== 2'd1) begin n_bad++; $display("FAIL random_mode got %0d want 1", flip_mode_o); end
        n_cmp++; if (flip_index_o !== 2'd2) begin n_bad++; $display("FAIL random_index got %0d want 2", flip_index_o); end
        n_cmp++; if (flip_break_o !== 5'd1) begin n_bad++; $display("FAIL random_break got %0d want 1", flip_break_o); end
        n_cmp++; if (flip_literal_o !== 12'h123) begin n_bad++; $display("FAIL random_literal got %0h want 123", flip_literal_o); end
        finish_flip();
    endtask

    task automatic test_threshold();
        int n;
        set_breaks(20'h00101, 20'hFFFFF, 20'h80000, 20'hFFFFF, 20'h00040, 20'hFFFFF);
        random_i = 32'h6E147AE0;
        start_clause(CL_A, 1'b0);
        wait_flip(1, n);
        n_cmp++; if (flip_mode_o !== 2'd2) begin n_bad++; $display("FAIL thresh_eq_mode got %0d want 2", flip_mode_o); end
        finish_flip();
        random_i = 32'h6E147ADF;
        start_clause(CL_A, 1'b0);
        wait_flip(1, n);
        n_cmp++; if (flip_mode_o !== 2'd1) begin n_bad++; $display("FAIL thresh_below_mode got %0d want 1", flip_mode_o); end
        n_cmp++; if (flip_index_o !== 2'd1) begin n_bad++; $display("FAIL thresh_below_index got %0d want 1", flip_index_o); end
        finish_flip();
    endtask

    task automatic test_mask_latency();
        int n;
        set_breaks(20'hFFFFF, 20'h0000F, 20'hFFFFF, 20'h0000F, 20'hFFFFF, 20'h0000F);
        random_i = 32'hFFFFFFFF;
        start_clause(CL_A, 1'b0);
        wait_flip(1, n);
        n_cmp++; if (n != 8) begin n_bad++; $display("FAIL latency got %0d cycles want 8", n); end
        n_cmp++; if (flip_mode_o !== 2'd2) begin n_bad++; $display("FAIL mask_mode got %0d want 2", flip_mode_o); end
        n_cmp++; if (flip_index_o !== 2'd0) begin n_bad++; $display("FAIL mask_index got %0d want 0", flip_index_o); end
        n_cmp++; if (flip_break_o !== 5'd4) begin n_bad++; $display("FAIL mask_break got %0d want 4", flip_break_o); end
        n_cmp++; if (flip_literal_o !== 12'h005) begin n_bad++; $display("FAIL mask_literal got %0h want 005", flip_literal_o); end
        finish_flip();
    endtask

    task automatic test_back_to_back();
        int n;
        set_breaks(20'h00101, 20'hFFFFF, 20'h80000, 20'hFFFFF, 20'h00040, 20'hFFFFF);
        random_i = 32'hFFFFFFFF;
        start_clause(CL_A, 1'b1);
        clause_i = CL_B;
        wait_flip(1, n);
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (flip_valid_o !== 1'b1) begin n_bad++; $display("FAIL hold_valid c=%0d got %0b want 1", c, flip_valid_o); end
            n_cmp++; if (flip_mode_o !== 2'd2) begin n_bad++; $display("FAIL hold_mode c=%0d got %0d want 2", c, flip_mode_o); end
            n_cmp++; if (flip_index_o !== 2'd1) begin n_bad++; $display("FAIL hold_index c=%0d got %0d want 1", c, flip_index_o); end
            n_cmp++; if (flip_literal_o !== 12'h80A) begin n_bad++; $display("FAIL hold_literal c=%0d got %0h want 80a", c, flip_literal_o); end
            n_cmp++; if (clause_ready_o !== 1'b0) begin n_bad++; $display("FAIL hold_ready c=%0d got %0b want 0", c, clause_ready_o); end
            @(negedge clk);
        end
        flip_ready_i = 1'b1;
        @(negedge clk);
        flip_ready_i = 1'b0;
        n_cmp++; if (clause_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %0b want 1", clause_ready_o); end
        n_cmp++; if (flip_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_flip_drop got %0b want 0", flip_valid_o); end
        @(negedge clk);
        clause_valid_i = 1'b0;
        n_cmp++; if (lk_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got %0b want 1", lk_valid_o); end
        n_cmp++; if (lk_literal_o !== 12'h1C3) begin n_bad++; $display("FAIL b2b_lk_literal got %0h want 1c3", lk_literal_o); end
        wait_flip(1, n);
        n_cmp++; if (n != 8) begin n_bad++; $display("FAIL b2b_latency got %0d cycles want 8", n); end
        n_cmp++; if (flip_literal_o !== 12'h444) begin n_bad++; $display("FAIL b2b_literal got %0h want 444", flip_literal_o); end
        finish_flip();
    endtask

    task automatic test_reset_mid();
        random_i = 32'hFFFFFFFF;
        start_clause(CL_A, 1'b0);
        @(negedge clk);
        n_cmp++; if (lk_index_o !== 2'd1) begin n_bad++; $display("FAIL mid_k got %0d want 1", lk_index_o); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (lk_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_lk_valid got %0b want 0", lk_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %0b want 0", busy_o); end
        n_cmp++; if (flip_literal_o !== '0) begin n_bad++; $display("FAIL mid_flip_literal got %0h want 0", flip_literal_o); end
        n_cmp++; if (flip_mode_o !== 2'd0) begin n_bad++; $display("FAIL mid_flip_mode got %0d want 0", flip_mode_o); end
        n_cmp++; if (flip_index_o !== 2'd0) begin n_bad++; $display("FAIL mid_flip_index got %0d want 0", flip_index_o); end
        n_cmp++; if (flip_break_o !== 5'd0) begin n_bad++; $display("FAIL mid_flip_break got %0d want 0", flip_break_o); end
        reset = 1'b0;
        #1;
        n_cmp++; if (clause_ready_o !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %0b want 1", clause_ready_o); end
        repeat (6) @(negedge clk);
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL mid_err_clean got %0b want 0", err_o); end
        stray_req++;
        repeat (3) @(negedge clk);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL stray_err got %0b want 1", err_o); end
        repeat (5) @(negedge clk);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL stray_sticky got %0b want 1", err_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL stray_busy got %0b want 0", busy_o); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL stray_clear got %0b want 0", err_o); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pipe_v[i]   = 1'b0;
            pipe_idx[i] = '0;
        end
        set_breaks('0, '0, '0, '0, '0, '0);
        fork
            responder();
        join_none
        test_reset();
        test_freebie();
        test_greedy();
        test_random();
        test_threshold();
        test_mask_latency();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
